// File: rtl/isa_pkg.sv
// isa_pkg: opcode set shared with the core, plus the fetch-side state and
// buffer-entry types used by instr_fetch and fetch_fifo.
package isa_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0,
      OP_LOAD  = 4'h1,
      OP_STORE = 4'h2,
      OP_ADD   = 4'h3,
      OP_SUB   = 4'h4,
      OP_AND   = 4'h5,
      OP_OR    = 4'h6,
      OP_JMP   = 4'h7,
      OP_BRZ   = 4'h8,
      OP_CALL  = 4'h9,
      OP_RET   = 4'hA,
      OP_HALT  = 4'hF
   } opcode_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_t;

   // pc in the upper half so {instr_pc, instr_word} unpacks the head directly
   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] word;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous buffer with flush; head is read straight from
// registers and forced to zero while empty.
module fetch_fifo
   import isa_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ENTRY_W,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
)(
   input  logic          clock,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_wr, do_rd;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_rd   = rd_en & ~empty;
   // a pop in the same cycle frees the slot, so a full buffer still captures
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (!reset_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: credit-limited ROM prefetcher feeding fetch_fifo.
// Defining FETCH_STATS_EN adds saturating fetch_count/stall_count outputs.
module instr_fetch
   import isa_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int ROM_LATENCY = 2
)(
   input  logic        clock,
   input  logic        reset_n,
   output logic [15:0] address_rom,
   input  logic [15:0] q_rom,
   output logic [15:0] instr_word,
   output logic [15:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0] fetch_count,
   output logic [15:0] stall_count
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t               state, state_nxt;
   logic                       run, redirect_taken, issue;
   logic                       fifo_full, fifo_empty;
   logic [15:0]                fetch_pc;
   logic [ROM_LATENCY:1]       vld_pipe;
   logic [ROM_LATENCY:1][15:0] pc_pipe;
   logic [CW-1:0]              fifo_count, inflight, credit;
   logic [ENTRY_W-1:0]         head;
   fetch_entry_t               cap;

   always_ff @(posedge clock) begin
      if (!reset_n) state <= ST_INIT;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: state_nxt = ST_RUN;
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_INIT;
      endcase
   end

   always_comb begin
      run = 1'b0;
      case (state)
         ST_RUN:  run = 1'b1;
         default: run = 1'b0;
      endcase
   end

   always_comb begin
      inflight = '0;
      for (int k = 1; k <= ROM_LATENCY; k++) inflight = inflight + CW'(vld_pipe[k]);
   end

   // a redirect cycle issues nothing: that read would be killed anyway
   assign redirect_taken = run & redirect_valid;
   assign credit         = fifo_count + inflight;
   assign issue          = run & ~redirect_taken & ~fifo_full & (credit < CW'(DEPTH));
   assign address_rom    = fetch_pc;

   always_ff @(posedge clock) begin
      if (!reset_n)            fetch_pc <= 16'h0000;
      else if (redirect_taken) fetch_pc <= redirect_pc;
      else if (issue)          fetch_pc <= fetch_pc + 16'd1;
   end

   // vld_pipe[k] marks a read issued k cycles ago; stage ROM_LATENCY meets q_rom
   always_ff @(posedge clock) begin
      if (!reset_n || redirect_taken) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= issue;
         for (int k = 2; k <= ROM_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   always_ff @(posedge clock) begin
      pc_pipe[1] <= fetch_pc;
      for (int k = 2; k <= ROM_LATENCY; k++) pc_pipe[k] <= pc_pipe[k-1];
   end

   always_comb begin
      cap      = '0;
      cap.pc   = pc_pipe[ROM_LATENCY];
      cap.word = q_rom;
   end

   fetch_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (redirect_taken),
      .wr_en   (vld_pipe[ROM_LATENCY]),
      .wr_data (cap),
      .rd_en   (instr_ready),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign instr_valid           = ~fifo_empty;
   assign {instr_pc, instr_word} = head;

`ifdef FETCH_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         fetch_count <= 16'h0000;
         stall_count <= 16'h0000;
      end else begin
         if (issue && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
         if (instr_valid && !instr_ready && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule
